agu_radix_gen: RTL and testbench

Parametrised address generation unit for the NTT/NWC butterfly stages. For each butterfly group j = 0 … 2^k−1 it emits the 2^RADIX coefficient addresses of that group in one beat: order[m] = (rev_k(j) << RADIX) + m. rev_k is k-bit bit reversal, or identity when bit reversal is disabled. It sits between the stage controller (start/done) and the memory/butterfly datapath (valid/ready). Compared with the fixed-radix k2 generator it adds:
- runtime k and stage tag;
- selectable index order;
- output backpressure;
- an exact beat count.

---
 rtl/agu_radix_gen_if.sv | 32 +++
 rtl/agu_radix_gen.sv | 122 ++++++++++++
 tb/tb_agu_radix_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/agu_radix_gen_if.sv
// Handshake/config bundle between stage controller, agu_radix_gen and the butterfly datapath.
// slave = address generator side, master = controller/consumer side.
interface agu_radix_gen_if #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned RADIX   = 1,
  parameter int unsigned K_MAX   = 12,
  parameter int unsigned KW      = $clog2(K_MAX + 1)
);
  localparam int unsigned LANES = 1 << RADIX;

  logic                     start;
  logic [KW-1:0]            cfg_k;
  logic                     cfg_bitrev;
  logic [D_WIDTH-1:0]       cfg_l;
  logic                     out_ready;
  logic [LANES*D_WIDTH-1:0] order;
  logic                     out_valid;
  logic                     last;
  logic [D_WIDTH-1:0]       l_out;
  logic                     busy;
  logic                     done;

  modport master (
    output start, cfg_k, cfg_bitrev, cfg_l, out_ready,
    input  order, out_valid, last, l_out, busy, done
  );

  modport slave (
    input  start, cfg_k, cfg_bitrev, cfg_l, out_ready,
    output order, out_valid, last, l_out, busy, done
  );
endinterface

// File: rtl/agu_radix_gen.sv
// Butterfly-group address generator: one beat of 2^RADIX lane addresses per group j,
// optionally bit-reversed over a runtime k, with registered valid/ready output.
module agu_radix_gen #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned RADIX   = 1,
  parameter int unsigned K_MAX   = 12,
  parameter int unsigned KW      = $clog2(K_MAX + 1)
) (
  input logic            clk,
  input logic            rst_n,
  agu_radix_gen_if.slave bus_io
);
  localparam int unsigned LANES = 1 << RADIX;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [K_MAX-1:0]         j_q, j_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     bitrev_q, bitrev_d;
  logic [D_WIDTH-1:0]       l_q, l_d;
  logic [LANES*D_WIDTH-1:0] order_q, order_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     done_q, done_d;

  logic [K_MAX-1:0]         k_mask, rev_full, idx;
  logic [LANES*D_WIDTH-1:0] lanes;
  logic                     j_last, load;

  // Reverse all K_MAX bits, then shift down so only bits [k-1:0] are mirrored.
  always_comb begin
    k_mask = ~({K_MAX{1'b1}} << k_q);
    j_last = (j_q == k_mask);
    for (int i = 0; i < K_MAX; i++) begin
      rev_full[i] = j_q[K_MAX-1-i];
    end
    idx = bitrev_q ? (rev_full >> (K_MAX - 32'(k_q))) : j_q;
    for (int m = 0; m < LANES; m++) begin
      lanes[m*D_WIDTH +: D_WIDTH] = (D_WIDTH'(idx) << RADIX) + D_WIDTH'(m);
    end
  end

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    k_d      = k_q;
    bitrev_d = bitrev_q;
    l_d      = l_q;
    order_d  = order_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    load     = !valid_q || bus_io.out_ready;
    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d  = StRun;
          k_d      = bus_io.cfg_k;
          bitrev_d = bus_io.cfg_bitrev;
          l_d      = bus_io.cfg_l;
          j_d      = '0;
        end
      end
      StRun: begin
        if (load) begin
          order_d = lanes;
          valid_d = 1'b1;
          last_d  = j_last;
          if (j_last) begin
            state_d = StFlush;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      StFlush: begin
        // Final beat sits in the output register until the consumer takes it.
        if (bus_io.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      j_q      <= '0;
      k_q      <= '0;
      bitrev_q <= 1'b0;
      l_q      <= '0;
      order_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      bitrev_q <= bitrev_d;
      l_q      <= l_d;
      order_q  <= order_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign bus_io.order     = order_q;
  assign bus_io.out_valid = valid_q;
  assign bus_io.last      = last_q;
  assign bus_io.l_out     = l_q;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = done_q;
endmodule

// File: tb/tb_agu_radix_gen.sv
// Directed bench for agu_radix_gen: RADIX=1 and RADIX=2 instances, scoreboard of expected beats
// filled at start and drained by per-instance monitors on the falling edge.
module tb_agu_radix_gen;
  logic clk;
  logic rst_n;

  agu_radix_gen_if #(.D_WIDTH(32), .RADIX(1), .K_MAX(12)) ia ();
  agu_radix_gen_if #(.D_WIDTH(32), .RADIX(2), .K_MAX(12)) ib ();

  agu_radix_gen #(.D_WIDTH(32), .RADIX(1), .K_MAX(12)) u_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ia)
  );

  agu_radix_gen #(.D_WIDTH(32), .RADIX(2), .K_MAX(12)) u_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (ib)
  );

  typedef struct packed {
    logic [127:0] order;
    logic         last;
    logic [31:0]  l;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rev_k(input int j, input int k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < k; i++) r[i] = j[k-1-i];
    return r;
  endfunction

  // Cycle (edges after the accepting start edge) at which done is expected.
  function automatic int done_model(input int k, input int mode);
    int vis;
    int c;
    vis = 1;
    for (int i = 0; i < (1 << k); i++) begin
      c = vis;
      while (!(mode == 0 || (c % 3) == 0)) c++;
      vis = c + 1;
    end
    return vis;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ia.out_valid) begin
      check("a_beat_pending", 128'(qa.size() > 0), 128'(1));
      if (qa.size() > 0) begin
        check("a_order", {64'd0, ia.order}, qa[0].order);
        check("a_last", 128'(ia.last), 128'(qa[0].last));
        check("a_l_out", 128'(ia.l_out), 128'(qa[0].l));
        if (ia.out_ready) void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ib.out_valid) begin
      check("b_beat_pending", 128'(qb.size() > 0), 128'(1));
      if (qb.size() > 0) begin
        check("b_order", ib.order, qb[0].order);
        check("b_last", 128'(ib.last), 128'(qb[0].last));
        check("b_l_out", 128'(ib.l_out), 128'(qb[0].l));
        if (ib.out_ready) void'(qb.pop_front());
      end
    end
  end

  task automatic do_start(input bit sel, input int k, input bit br, input logic [31:0] l,
                          input string tag);
    exp_t        e;
    int          rdx;
    logic [31:0] base;
    rdx = sel ? 2 : 1;
    for (int j = 0; j < (1 << k); j++) begin
      base    = br ? rev_k(j, k) : 32'(j);
      e.order = '0;
      for (int m = 0; m < (1 << rdx); m++) e.order[m*32 +: 32] = (base << rdx) + 32'(m);
      e.last  = (j == (1 << k) - 1);
      e.l     = l;
      if (sel) qb.push_back(e);
      else qa.push_back(e);
    end
    if (sel) begin
      ib.start = 1'b1; ib.cfg_k = 4'(k); ib.cfg_bitrev = br; ib.cfg_l = l;
    end else begin
      ia.start = 1'b1; ia.cfg_k = 4'(k); ia.cfg_bitrev = br; ia.cfg_l = l;
    end
    @(posedge clk); #1;
    ia.start = 1'b0;
    ib.start = 1'b0;
    check({tag, "_busy_on_start"}, 128'(sel ? ib.busy : ia.busy), 128'(1));
    check({tag, "_valid_latency"}, 128'(sel ? ib.out_valid : ia.out_valid), 128'(0));
    check({tag, "_done_low"}, 128'(sel ? ib.done : ia.done), 128'(0));
  endtask

  // Called just after the accepting edge; returns at the falling edge of the done cycle.
  task automatic run_wait(input bit sel, input int exp_c, input int mode, input int poke_c,
                          input string tag);
    int got;
    bit r;
    got = -1;
    for (int c = 0; c < 200; c++) begin
      r = (mode == 0) || ((c % 3) == 0);
      if (sel) ib.out_ready = r;
      else ia.out_ready = r;
      if (c == poke_c) begin
        ia.start = 1'b1; ia.cfg_k = 4'd1; ia.cfg_bitrev = 1'b0; ia.cfg_l = 32'hDEAD;
      end
      @(negedge clk);
      if (sel ? ib.done : ia.done) begin
        got = c;
        break;
      end
      @(posedge clk); #1;
      ia.start = 1'b0;
    end
    check({tag, "_done_cycle"}, 128'(got), 128'(exp_c));
    check({tag, "_busy_at_done"}, 128'(sel ? ib.busy : ia.busy), 128'(0));
    check({tag, "_valid_at_done"}, 128'(sel ? ib.out_valid : ia.out_valid), 128'(0));
    check({tag, "_sb_empty"}, 128'(sel ? qb.size() : qa.size()), 128'(0));
    ia.out_ready = 1'b1;
    ib.out_ready = 1'b1;
  endtask

  task automatic done_drop(input bit sel, input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse_len"}, 128'(sel ? ib.done : ia.done), 128'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_valid"}, 128'(ia.out_valid), 128'(0));
    check({tag, "_a_busy"}, 128'(ia.busy), 128'(0));
    check({tag, "_a_done"}, 128'(ia.done), 128'(0));
    check({tag, "_a_last"}, 128'(ia.last), 128'(0));
    check({tag, "_a_order"}, 128'(ia.order), 128'(0));
    check({tag, "_a_l_out"}, 128'(ia.l_out), 128'(0));
    check({tag, "_b_valid"}, 128'(ib.out_valid), 128'(0));
    check({tag, "_b_busy"}, 128'(ib.busy), 128'(0));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    ia.start = 1'b0; ia.cfg_k = '0; ia.cfg_bitrev = 1'b0; ia.cfg_l = '0; ia.out_ready = 1'b1;
    ib.start = 1'b0; ib.cfg_k = '0; ib.cfg_bitrev = 1'b0; ib.cfg_l = '0; ib.out_ready = 1'b1;
    #3;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // k=3, bit-reversed, no backpressure
    do_start(1'b0, 3, 1'b1, 32'h0000_00A5, "a_k3_rev");
    run_wait(1'b0, done_model(3, 0), 0, -1, "a_k3_rev");
    done_drop(1'b0, "a_k3_rev");

    // RADIX=2 natural order, then a back-to-back sweep started in the done cycle
    do_start(1'b1, 2, 1'b0, 32'h0000_1234, "b_k2_nat");
    run_wait(1'b1, done_model(2, 0), 0, -1, "b_k2_nat");
    do_start(1'b1, 1, 1'b1, 32'h0000_0077, "b_bubble");
    run_wait(1'b1, done_model(1, 0), 0, -1, "b_bubble");
    done_drop(1'b1, "b_bubble");

    // Backpressure: ready high one cycle in three
    do_start(1'b0, 3, 1'b1, 32'h0000_0B0B, "a_stall");
    run_wait(1'b0, done_model(3, 1), 1, -1, "a_stall");
    done_drop(1'b0, "a_stall");

    // k=0: single beat, lanes equal m
    do_start(1'b0, 0, 1'b1, 32'h0000_0C0C, "a_k0");
    run_wait(1'b0, done_model(0, 0), 0, -1, "a_k0");
    done_drop(1'b0, "a_k0");

    // start pulsed mid-sweep with a different k must be ignored
    do_start(1'b0, 3, 1'b0, 32'h0000_0D0D, "a_poke");
    run_wait(1'b0, done_model(3, 0), 0, 3, "a_poke");
    done_drop(1'b0, "a_poke");
    check("a_poke_no_restart", 128'(ia.busy), 128'(0));

    // Reset during beat 3 of 8: immediate clear, no done, then a fresh full sweep
    do_start(1'b0, 3, 1'b1, 32'h0000_0E0E, "a_abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    qa.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ia.done) seen++;
    end
    check("abort_no_done", 128'(seen), 128'(0));
    @(posedge clk); #1;
    do_start(1'b0, 3, 1'b1, 32'h0000_0F0F, "a_fresh");
    run_wait(1'b0, done_model(3, 0), 0, -1, "a_fresh");
    done_drop(1'b0, "a_fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
